uart_ram_loader: RTL and testbench

- Boot-time program loader: receives a framed program image over a serial line and writes it into the computer's main RAM as 16-bit words.
- Holds the CPU off the bus while a load is in progress.
- Write-side counterpart to the simulation flow that inspects RAM contents; lets real hardware fill RAM that would otherwise be preloaded.
- Sits beside the CPU on the RAM write port; the top level muxes RAM access on cpu_hold.

---
 rtl/uart_ram_loader.sv | 167 ++++++++++++++++
 tb/tb_uart_ram_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_loader.sv
// Boot loader: 8N1 UART frames (A5, LEN, N words, XOR csum) written to RAM as 16-bit words.
// Write strobe lands one cycle after each LO byte; no backpressure, RAM port is owned while cpu_hold is high.
module uart_ram_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 13,
  parameter int BASE_ADDR    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                CW   = $clog2(CLKS_PER_BIT);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [7:0]        SYNC = 8'hA5;

  typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAIT} ustate_t;
  typedef enum logic [2:0] {
    L_IDLE, L_LEN_HI, L_LEN_LO, L_DATA_HI, L_DATA_LO, L_CSUM, L_FAIL
  } lstate_t;

  logic          rx_m, rx_s, rx_q;
  ustate_t       u_state, u_next;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_byte;
  logic          half_tick, bit_tick;
  logic          byte_valid, frame_err;

  lstate_t       l_state, l_next;
  logic [7:0]    len_hi, data_hi, csum;
  logic [15:0]   remain, len_full;
  logic          len_too_big;
  logic          start_frame, write_word, data_byte, csum_good, enter_fail;

  // rx_q holds the previous synchronized sample for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      {rx_m, rx_s, rx_q} <= 3'b111;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  assign half_tick = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign bit_tick  = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset) u_state <= U_IDLE;
    else       u_state <= u_next;
  end

  always_comb begin
    u_next = u_state;
    unique case (u_state)
      U_IDLE:  if (rx_q && !rx_s) u_next = U_START;
      U_START: if (half_tick) u_next = rx_s ? U_IDLE : U_DATA;
      U_DATA:  if (bit_tick && bit_cnt == 3'd7) u_next = U_STOP;
      U_STOP:  if (bit_tick) u_next = U_WAIT;
      U_WAIT:  if (rx_s) u_next = U_IDLE;
      default: u_next = U_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = (u_state == U_STOP) && bit_tick && rx_s;
    frame_err  = (u_state == U_STOP) && bit_tick && !rx_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
      rx_byte <= '0;
    end else begin
      if (u_state == U_IDLE || u_state == U_WAIT || bit_tick ||
          (u_state == U_START && half_tick))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (u_state == U_START) bit_cnt <= '0;
      if (u_state == U_DATA && bit_tick) begin
        rx_byte <= {rx_s, rx_byte[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign len_full    = {len_hi, rx_byte};
  assign len_too_big = ({16'd0, len_full} > (32'd1 << ADDR_W));

  always_ff @(posedge clk) begin
    if (reset) l_state <= L_IDLE;
    else       l_state <= l_next;
  end

  always_comb begin
    l_next = l_state;
    if (frame_err && l_state != L_IDLE) begin
      l_next = L_FAIL;
    end else if (byte_valid) begin
      unique case (l_state)
        L_IDLE, L_FAIL: if (rx_byte == SYNC) l_next = L_LEN_HI;
        L_LEN_HI:  l_next = L_LEN_LO;
        L_LEN_LO:  l_next = (len_full == 16'd0) ? L_CSUM :
                            len_too_big ? L_FAIL : L_DATA_HI;
        L_DATA_HI: l_next = L_DATA_LO;
        L_DATA_LO: l_next = (remain == 16'd1) ? L_CSUM : L_DATA_HI;
        L_CSUM:    l_next = (rx_byte == csum) ? L_IDLE : L_FAIL;
        default:   l_next = L_IDLE;
      endcase
    end
  end

  always_comb begin
    start_frame = byte_valid && rx_byte == SYNC &&
                  (l_state == L_IDLE || l_state == L_FAIL);
    write_word  = byte_valid && l_state == L_DATA_LO;
    data_byte   = byte_valid && (l_state == L_DATA_HI || l_state == L_DATA_LO);
    csum_good   = byte_valid && l_state == L_CSUM && rx_byte == csum;
    enter_fail  = (l_next == L_FAIL) && (l_state != L_FAIL);
    busy        = (l_state != L_IDLE) && (l_state != L_FAIL);
    cpu_hold    = (l_state != L_IDLE);
  end

  // address advances the cycle after the strobe so it stays stable while mem_we is high
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= BASE;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      len_hi    <= '0;
      data_hi   <= '0;
      remain    <= '0;
      csum      <= '0;
    end else begin
      mem_we <= write_word;
      if (write_word) mem_wdata <= {data_hi, rx_byte};
      if (start_frame)  mem_addr <= BASE;
      else if (mem_we)  mem_addr <= mem_addr + 1'b1;
      if (byte_valid && l_state == L_LEN_HI)  len_hi  <= rx_byte;
      if (byte_valid && l_state == L_LEN_LO)  remain  <= len_full;
      if (byte_valid && l_state == L_DATA_HI) data_hi <= rx_byte;
      if (write_word) remain <= remain - 1'b1;
      if (data_byte)  csum   <= csum ^ rx_byte;
      if (start_frame) begin
        done <= 1'b0;
        err  <= 1'b0;
        csum <= '0;
      end
      if (csum_good)  done <= 1'b1;
      if (enter_fail) err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed and randomized frames for uart_ram_loader, checked against a frame-level model.
module tb_uart_ram_loader;
  localparam int CPB = 4;
  localparam int AW  = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_we, cpu_hold, busy, done, err;

  int compared = 0;
  int mismatched = 0;

  logic [AW-1:0] got_addr[$];
  logic [15:0]   got_data[$];
  logic [15:0]   words[$];

  uart_ram_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp)
    else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b1);
  endtask

  function automatic logic [7:0] words_xor();
    logic [7:0] x;
    x = 8'h00;
    foreach (words[i]) x = x ^ words[i][15:8] ^ words[i][7:0];
    return x;
  endfunction

  task automatic send_frame(input int n, input logic [7:0] cs);
    logic [15:0] nn;
    nn = 16'(n);
    send_byte(8'hA5);
    send_byte(nn[15:8]);
    send_byte(nn[7:0]);
    for (int i = 0; i < n; i++) begin
      send_byte(words[i][15:8]);
      send_byte(words[i][7:0]);
    end
    send_byte(cs);
  endtask

  // model: a frame of n words writes words[i] to (i mod DEPTH) when n fits, else nothing
  task automatic check_frame(input string tag, input int n, input bit good);
    int exp_w;
    exp_w = (n <= DEPTH) ? n : 0;
    check({tag, ".writes"}, got_addr.size(), exp_w);
    for (int i = 0; i < exp_w; i++) begin
      if (i < got_addr.size()) begin
        check($sformatf("%s.addr%0d", tag, i), got_addr[i], i % DEPTH);
        check($sformatf("%s.data%0d", tag, i), got_data[i], words[i]);
      end
    end
    check({tag, ".done"}, done, good);
    check({tag, ".err"}, err, !good);
    check({tag, ".hold"}, cpu_hold, !good);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".addr_end"}, mem_addr, (n <= DEPTH) ? (n % DEPTH) : 0);
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".we"}, mem_we, 0);
    check({tag, ".addr"}, mem_addr, 0);
    check({tag, ".wdata"}, mem_wdata, 0);
    check({tag, ".hold"}, cpu_hold, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".err"}, err, 0);
  endtask

  initial begin
    int n;
    bit good;
    logic [7:0] cs;

    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    words = '{16'h1234, 16'hABCD};
    send_frame(2, 8'h40);
    check_frame("good2", 2, 1);

    send_frame(2, 8'h41);
    check_frame("badcsum", 2, 0);
    send_frame(2, 8'h40);
    check_frame("resend", 2, 1);

    words.delete();
    send_byte(8'h55);
    send_frame(0, 8'h00);
    check_frame("zerolen", 0, 1);

    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h11);
    check_frame("toolong", 17, 0);

    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back(16'($urandom));
    send_frame(DEPTH, words_xor());
    check_frame("full", DEPTH, 1);

    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rx = 1'b1;
    repeat (6 * CPB) @(negedge clk);
    check("glitch.writes", got_addr.size(), 0);
    check("glitch.done", done, 1);
    check("glitch.busy", busy, 0);
    check("glitch.err", err, 0);

    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    check("ferr.busy_mid", busy, 1);
    check("ferr.hold_mid", cpu_hold, 1);
    send_bits(8'h3C, 1'b0);
    check("ferr.err", err, 1);
    check("ferr.done", done, 0);
    check("ferr.hold", cpu_hold, 1);
    check("ferr.busy", busy, 0);
    check("ferr.writes", got_addr.size(), 0);

    words = '{16'h1122, 16'h3344};
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("midrst.writes", got_addr.size(), 1);
    check("midrst.busy", busy, 1);
    got_addr.delete();
    got_data.delete();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h44);
    check("postrst.writes", got_addr.size(), 0);
    check("postrst.busy", busy, 0);
    check("postrst.done", done, 0);
    words = '{16'hBEEF, 16'h00A5, 16'hA5A5};
    send_frame(3, words_xor());
    check_frame("fresh", 3, 1);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(0, 8'hA4)));
      words.delete();
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(DEPTH + 1, DEPTH + 4);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'(n));
        check_frame($sformatf("rnd%0d", it), n, 0);
      end else begin
        n = $urandom_range(0, 8);
        for (int i = 0; i < n; i++) words.push_back(16'($urandom));
        good = ($urandom_range(0, 3) != 0);
        cs = good ? words_xor() : (words_xor() ^ 8'($urandom_range(1, 255)));
        send_frame(n, cs);
        check_frame($sformatf("rnd%0d", it), n, good);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
